// File: rtl/puf_eval_scheduler.sv
// puf_eval_scheduler: round-robin PUF request scheduler with repeated evaluation and per-bit majority vote
module puf_eval_scheduler #(
  parameter int CHALLENGE_WIDTH  = 64,
  parameter int PDL_CONFIG_WIDTH = 64,
  parameter int RESPONSE_WIDTH   = 6,
  parameter int NUM_EVALS        = 15,
  parameter int TIMEOUT          = 63
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req_valid,
  input  logic [CHALLENGE_WIDTH-1:0]  req0_challenge,
  input  logic [PDL_CONFIG_WIDTH-1:0] req0_pdl,
  input  logic [CHALLENGE_WIDTH-1:0]  req1_challenge,
  input  logic [PDL_CONFIG_WIDTH-1:0] req1_pdl,
  output logic [1:0]                  req_ack,
  output logic                        puf_trigger,
  output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
  output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
  input  logic                        puf_done,
  input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
  input  logic                        puf_xor_response,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic [RESPONSE_WIDTH-1:0]   rsp_raw,
  output logic                        rsp_xor,
  output logic                        rsp_timeout
);
  localparam int CW = $clog2(NUM_EVALS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] NE   = CW'(NUM_EVALS);
  localparam logic [CW-1:0] HALF = CW'(NUM_EVALS / 2);
  localparam logic [WW-1:0] TO   = WW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, GAP, RESP} state_t;
  state_t r_state, w_next;
  logic [1:0]                  r_ack;
  logic [CHALLENGE_WIDTH-1:0]  r_chal;
  logic [PDL_CONFIG_WIDTH-1:0] r_pdl;
  logic                        r_id, r_last, r_to;
  logic [CW-1:0]               r_ones [RESPONSE_WIDTH];
  logic [CW-1:0]               r_xones, r_evals;
  logic [WW-1:0]               r_wait;
  logic                        w_gid, w_grant, w_ok;
  logic [CW-1:0]               w_evals;
  logic [WW-1:0]               w_wait;
  // Both pending: serve the one not served last; otherwise serve whoever asks
  assign w_gid   = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_grant = (r_state == IDLE) && (|req_valid);
  assign w_evals = r_evals + CW'(1);
  assign w_wait  = r_wait + WW'(1);
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (|req_valid) ? LAUNCH : IDLE;
      LAUNCH:  w_next = WAIT;
      WAIT:    w_next = puf_done ? ((w_evals == NE) ? RESP : GAP) : ((w_wait == TO) ? RESP : WAIT);
      GAP:     w_next = LAUNCH;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= '0;
      r_chal  <= '0;
      r_pdl   <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_to    <= 1'b0;
      r_xones <= '0;
      r_evals <= '0;
      r_wait  <= '0;
      for (int i = 0; i < RESPONSE_WIDTH; i++) r_ones[i] <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_ack   <= w_gid ? 2'b10 : 2'b01;
        r_chal  <= w_gid ? req1_challenge : req0_challenge;
        r_pdl   <= w_gid ? req1_pdl : req0_pdl;
        r_id    <= w_gid;
        r_last  <= w_gid;
        r_to    <= 1'b0;
        r_xones <= '0;
        r_evals <= '0;
        for (int i = 0; i < RESPONSE_WIDTH; i++) r_ones[i] <= '0;
      end
      if (r_state == LAUNCH) r_wait <= '0;
      if (r_state == WAIT) begin
        r_wait <= w_wait;
        if (puf_done) begin
          r_evals <= w_evals;
          r_xones <= r_xones + CW'(puf_xor_response);
          for (int i = 0; i < RESPONSE_WIDTH; i++) r_ones[i] <= r_ones[i] + CW'(puf_raw_response[i]);
        end else if (w_wait == TO) r_to <= 1'b1;
      end
    end
  end
  assign req_ack        = r_ack;
  assign puf_trigger    = (r_state == LAUNCH);
  assign puf_challenge  = r_chal;
  assign puf_pdl_config = r_pdl;
  assign rsp_valid      = (r_state == RESP);
  assign rsp_id         = r_id;
  assign rsp_timeout    = rsp_valid && r_to;
  assign w_ok           = rsp_valid && !r_to;
  assign rsp_xor        = w_ok && (r_xones > HALF);
  always_comb begin
    rsp_raw = '0;
    for (int i = 0; i < RESPONSE_WIDTH; i++) rsp_raw[i] = w_ok && (r_ones[i] > HALF);
  end
endmodule
